clk_period_meter: RTL

Measures the period and high time of a slow, asynchronous square wave, counted in clk_50 cycles. Typical inputs are divided clocks or pulse trains from board logic.
- It is the measuring end of the clock-divider path: the divider produces the slow clock, and this block reads it back and reports its timing.
- Results feed display/debug logic via a one-cycle valid strobe.

---
 rtl/clk_pkg.sv | 18 +
 rtl/clk_period_meter_if.sv | 22 ++
 rtl/sync_edge_det.sv | 41 ++++
 rtl/clk_period_meter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared clocking definitions for the divider and measurement blocks.
package clk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Half-period count for a divider producing out_hz from CLK_HZ.
  function automatic int unsigned half_period_cycles(input int unsigned out_hz);
    return CLK_HZ / (2 * out_hz);
  endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Control/result bundle of the period meter; master drives start/cont, slave reports results.
interface clk_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             cont;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  modport master (
    output start, cont,
    input  busy, valid, timeout, period, high_time
  );

  modport slave (
    input  start, cont,
    output busy, valid, timeout, period, high_time
  );
endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input and flags its rising/falling edges one cycle wide.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_50 or negedge rst_n) begin
          if (!rst_n) sync[0] <= 1'b0;
          else        sync[0] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk_50 or negedge rst_n) begin
          if (!rst_n) sync[gi] <= 1'b0;
          else        sync[gi] <= sync[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= sync[SYNC_STAGES-1];
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_50 cycles.
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 50_000_000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic               sig_in,
  clk_period_meter_if.slave  bus
);

  // Abort when the next count would reach TIMEOUT-1, so the strobe lands TIMEOUT-1 cycles after ARM entry.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);

  logic rise, fall, level;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .d      (sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
  logic             hi_seen_reg, hi_seen_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             timeout_reg, timeout_next;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hi_cnt_reg  <= '0;
      hi_seen_reg <= 1'b0;
      period_reg  <= '0;
      high_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_cnt_reg  <= hi_cnt_next;
      hi_seen_reg <= hi_seen_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_cnt_next  = hi_cnt_reg;
    hi_seen_next = hi_seen_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = ARM;
          cnt_next   = '0;
        end
      end

      ARM: begin
        if (rise) begin
          state_next   = MEASURE;
          cnt_next     = CNT_W'(1);
          hi_seen_next = 1'b0;
        end else if (cnt_reg >= TO_LAST) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // DONE in continuous mode is already the first cycle of the next measurement.
      MEASURE, DONE: begin
        if (state_reg == DONE && !bus.cont) begin
          state_next = IDLE;
        end else if (rise) begin
          state_next   = DONE;
          period_next  = cnt_reg;
          high_next    = hi_seen_reg ? hi_cnt_reg : cnt_reg;
          cnt_next     = CNT_W'(1);
          hi_seen_next = 1'b0;
        end else begin
          state_next = MEASURE;
          cnt_next   = cnt_reg + 1'b1;
          if (fall && !hi_seen_reg) begin
            hi_cnt_next  = cnt_reg;
            hi_seen_next = 1'b1;
          end else if (cnt_reg >= TO_LAST) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.valid     = (state_reg == DONE);
  assign bus.timeout   = timeout_reg;
  assign bus.period    = period_reg;
  assign bus.high_time = high_reg;

endmodule
